// File: rtl/input_reader_if.sv
// Bundle of the descriptor, host read request/completion, host data and output stream signals of input_reader.
// master is the input_reader side, slave is the surrounding system side.
interface input_reader_if #(
  parameter int VADDR_BITS = 48,
  parameter int LEN_BITS   = 28,
  parameter int DATA_WIDTH = 512
);
  logic                      desc_valid;
  logic                      desc_ready;
  logic [VADDR_BITS-1:0]     desc_vaddr;
  logic [LEN_BITS-1:0]       desc_len;

  logic                      rd_req_valid;
  logic                      rd_req_ready;
  logic [VADDR_BITS-1:0]     rd_req_vaddr;
  logic [LEN_BITS-1:0]       rd_req_len;
  logic                      rd_req_last;
  logic                      rd_cmpl_valid;

  logic [DATA_WIDTH-1:0]     s_tdata;
  logic [DATA_WIDTH/8-1:0]   s_tkeep;
  logic                      s_tlast;
  logic                      s_tvalid;
  logic                      s_tready;

  logic [DATA_WIDTH-1:0]     m_tdata;
  logic [DATA_WIDTH/8-1:0]   m_tkeep;
  logic                      m_tlast;
  logic                      m_tvalid;
  logic                      m_tready;

  logic                      done_valid;
  logic [LEN_BITS-1:0]       done_len;

  modport master (
    input  desc_valid, desc_vaddr, desc_len,
    output desc_ready,
    output rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_last,
    input  rd_req_ready, rd_cmpl_valid,
    input  s_tdata, s_tkeep, s_tlast, s_tvalid,
    output s_tready,
    output m_tdata, m_tkeep, m_tlast, m_tvalid,
    input  m_tready,
    output done_valid, done_len
  );

  modport slave (
    output desc_valid, desc_vaddr, desc_len,
    input  desc_ready,
    input  rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_last,
    output rd_req_ready, rd_cmpl_valid,
    output s_tdata, s_tkeep, s_tlast, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tkeep, m_tlast, m_tvalid,
    output m_tready,
    input  done_valid, done_len
  );
endinterface

// File: rtl/input_reader.sv
// Splits one host buffer descriptor into bounded read requests, tracks completions and forwards the data stream.
// Define INPUT_READER_STATS_EN to add the stat_bytes / stat_stall_cycles counters.
module input_reader #(
  parameter int TRANSFER_SIZE_BYTES = 65536,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int DATA_WIDTH          = 512,
  parameter int VADDR_BITS          = 48
) (
  input  logic                aclk,
  input  logic                aresetn,
`ifdef INPUT_READER_STATS_EN
  output logic [63:0]         stat_bytes,
  output logic [31:0]         stat_stall_cycles,
`endif
  input_reader_if.master      bus
);

  localparam int LEN_BITS   = 28;
  localparam int XFER_SHIFT = $clog2(TRANSFER_SIZE_BYTES);
  localparam int OUT_BITS   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_BITS-1:0]   XFER_LEN    = LEN_BITS'(TRANSFER_SIZE_BYTES);
  localparam logic [LEN_BITS-1:0]   XFER_MASK   = LEN_BITS'(TRANSFER_SIZE_BYTES - 1);
  localparam logic [VADDR_BITS-1:0] XFER_STRIDE = VADDR_BITS'(TRANSFER_SIZE_BYTES);
  localparam logic [OUT_BITS-1:0]   OUT_LIMIT   = OUT_BITS'(MAX_OUTSTANDING);
  localparam logic [LEN_BITS-1:0]   ONE         = LEN_BITS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic                  desc_ready_r;
  logic                  rd_req_valid_r;
  logic [VADDR_BITS-1:0] rd_req_vaddr_r;
  logic [LEN_BITS-1:0]   rd_req_len_r;
  logic                  rd_req_last_r;
  logic                  done_valid_r;
  logic [LEN_BITS-1:0]   done_len_r;

  logic [LEN_BITS-1:0]   buf_len;
  logic [LEN_BITS-1:0]   total_req;
  logic [LEN_BITS-1:0]   tail_len;
  logic [LEN_BITS-1:0]   req_idx;
  logic [LEN_BITS-1:0]   seg_cnt;
  logic [OUT_BITS-1:0]   outstanding;
  logic [OUT_BITS-1:0]   outstanding_nxt;
  logic                  data_done;
  logic                  data_done_nxt;

  logic                  desc_fire;
  logic                  req_fire;
  logic                  cmpl_hit;
  logic                  beat_last;
  logic                  final_seg;
  logic                  next_is_last;
  logic [LEN_BITS-1:0]   desc_total;
  logic [LEN_BITS-1:0]   desc_tail;

  // Request count is a ceiling shift; the tail is whatever the full-size requests leave over.
  assign desc_total = (bus.desc_len >> XFER_SHIFT) + LEN_BITS'(|(bus.desc_len & XFER_MASK));
  assign desc_tail  = bus.desc_len - ((desc_total - ONE) << XFER_SHIFT);

  assign desc_fire    = bus.desc_valid & desc_ready_r;
  assign req_fire     = rd_req_valid_r & bus.rd_req_ready;
  assign cmpl_hit     = bus.rd_cmpl_valid & (outstanding != '0);
  assign final_seg    = (state != IDLE) & (seg_cnt == total_req - ONE);
  assign beat_last    = bus.s_tvalid & bus.s_tready & bus.s_tlast & (state != IDLE);
  assign next_is_last = (req_idx + ONE) == (total_req - ONE);

  // A completion with nothing in flight is dropped so a reset mid-buffer cannot underflow the counter.
  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !cmpl_hit) begin
      outstanding_nxt = outstanding + OUT_BITS'(1);
    end else if (!req_fire && cmpl_hit) begin
      outstanding_nxt = outstanding - OUT_BITS'(1);
    end
  end

  assign data_done_nxt = data_done | (beat_last & final_seg);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      desc_ready_r   <= 1'b0;
      rd_req_valid_r <= 1'b0;
      rd_req_vaddr_r <= '0;
      rd_req_len_r   <= '0;
      rd_req_last_r  <= 1'b0;
      done_valid_r   <= 1'b0;
      done_len_r     <= '0;
      buf_len        <= '0;
      total_req      <= '0;
      tail_len       <= '0;
      req_idx        <= '0;
      seg_cnt        <= '0;
      outstanding    <= '0;
      data_done      <= 1'b0;
    end else begin
      done_valid_r <= 1'b0;
      outstanding  <= outstanding_nxt;
      if (state != IDLE) begin
        data_done <= data_done_nxt;
        if (beat_last) begin
          seg_cnt <= seg_cnt + ONE;
        end
      end
      case (state)
        IDLE: begin
          desc_ready_r <= !desc_fire;
          if (desc_fire) begin
            buf_len   <= bus.desc_len;
            total_req <= desc_total;
            tail_len  <= desc_tail;
            req_idx   <= '0;
            seg_cnt   <= '0;
            data_done <= 1'b0;
            if (bus.desc_len == '0) begin
              done_valid_r <= 1'b1;
              done_len_r   <= '0;
            end else begin
              state          <= ISSUE;
              rd_req_valid_r <= 1'b1;
              rd_req_vaddr_r <= bus.desc_vaddr;
              rd_req_last_r  <= (desc_total == ONE);
              rd_req_len_r   <= (desc_total == ONE) ? desc_tail : XFER_LEN;
            end
          end
        end
        ISSUE: begin
          if (req_fire) begin
            if (rd_req_last_r) begin
              rd_req_valid_r <= 1'b0;
              state          <= DRAIN;
            end else begin
              rd_req_valid_r <= (outstanding_nxt < OUT_LIMIT);
              req_idx        <= req_idx + ONE;
              rd_req_vaddr_r <= rd_req_vaddr_r + XFER_STRIDE;
              rd_req_last_r  <= next_is_last;
              rd_req_len_r   <= next_is_last ? tail_len : XFER_LEN;
            end
          end else if (!rd_req_valid_r) begin
            rd_req_valid_r <= (outstanding_nxt < OUT_LIMIT);
          end
        end
        DRAIN: begin
          if ((outstanding_nxt == '0) && data_done_nxt) begin
            done_valid_r <= 1'b1;
            done_len_r   <= buf_len;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.desc_ready   = desc_ready_r;
  assign bus.rd_req_valid = rd_req_valid_r;
  assign bus.rd_req_vaddr = rd_req_vaddr_r;
  assign bus.rd_req_len   = rd_req_len_r;
  assign bus.rd_req_last  = rd_req_last_r;
  assign bus.done_valid   = done_valid_r;
  assign bus.done_len     = done_len_r;

  // Data is a pure pass-through; only tlast is filtered down to the buffer's final beat.
  assign bus.m_tdata  = bus.s_tdata;
  assign bus.m_tkeep  = bus.s_tkeep;
  assign bus.m_tvalid = bus.s_tvalid;
  assign bus.m_tlast  = bus.s_tlast & final_seg;
  assign bus.s_tready = bus.m_tready;

`ifdef INPUT_READER_STATS_EN
  logic [64:0] bytes_sum;
  assign bytes_sum = {1'b0, stat_bytes} + 65'(done_len_r);

  // Both counters saturate instead of wrapping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_bytes        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (done_valid_r) begin
        stat_bytes <= bytes_sum[64] ? '1 : bytes_sum[63:0];
      end
      if (rd_req_valid_r && !bus.rd_req_ready && (stat_stall_cycles != '1)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_input_reader.sv
// Scoreboard bench for input_reader: stimulus queues expected requests, beats and done lengths; monitors pop and compare.
module tb_input_reader;

  localparam int XFER = 4096;
  localparam int MAXO = 2;
  localparam int DW   = 64;
  localparam int VB   = 48;
  localparam int LB   = 28;

  typedef struct {
    logic [VB-1:0] vaddr;
    logic [LB-1:0] len;
    logic          last;
  } req_t;

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic            last;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  req_t          req_q[$];
  beat_t         beat_q[$];
  logic [LB-1:0] done_q[$];
  req_t          mon_req;
  beat_t         mon_beat;
  logic [LB-1:0] mon_len;

  always #5 aclk = ~aclk;

  input_reader_if #(.VADDR_BITS(VB), .LEN_BITS(LB), .DATA_WIDTH(DW)) bus ();

`ifdef INPUT_READER_STATS_EN
  logic [63:0] stat_bytes;
  logic [31:0] stat_stall_cycles;
`endif

  input_reader #(
    .TRANSFER_SIZE_BYTES(XFER),
    .MAX_OUTSTANDING(MAXO),
    .DATA_WIDTH(DW),
    .VADDR_BITS(VB)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
`ifdef INPUT_READER_STATS_EN
    .stat_bytes(stat_bytes),
    .stat_stall_cycles(stat_stall_cycles),
`endif
    .bus(bus)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_req(input logic [VB-1:0] va, input logic [LB-1:0] ln, input logic last);
    req_t r;
    r.vaddr = va;
    r.len   = ln;
    r.last  = last;
    req_q.push_back(r);
  endtask

  task automatic send_desc(input logic [VB-1:0] va, input logic [LB-1:0] ln);
    int n;
    n = 0;
    bus.desc_vaddr = va;
    bus.desc_len   = ln;
    bus.desc_valid = 1'b1;
    while (!bus.desc_ready && n < 50) begin
      tick();
      n++;
    end
    check_output("desc_accept", 64'(bus.desc_ready), 64'd1);
    tick();
    bus.desc_valid = 1'b0;
  endtask

  task automatic pulse_cmpl();
    bus.rd_cmpl_valid = 1'b1;
    tick();
    bus.rd_cmpl_valid = 1'b0;
  endtask

  // One request's worth of data; the final beat carries s_tlast, optionally with a completion in the same cycle.
  task automatic send_segment(input logic [DW-1:0] base, input int nbeats, input logic final_seg,
                              input logic cmpl_on_last);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = base + DW'(i);
      b.keep = '1;
      b.last = final_seg && (i == nbeats - 1);
      beat_q.push_back(b);
      bus.s_tdata  = b.data;
      bus.s_tkeep  = '1;
      bus.s_tlast  = (i == nbeats - 1);
      bus.s_tvalid = 1'b1;
      if (cmpl_on_last && (i == nbeats - 1)) begin
        bus.rd_cmpl_valid = 1'b1;
      end
      tick();
      bus.rd_cmpl_valid = 1'b0;
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  always @(negedge aclk) begin
    if (bus.rd_req_valid && bus.rd_req_ready) begin
      if (req_q.size() == 0) begin
        check_output("unexpected_req", 64'(bus.rd_req_vaddr), 64'd0);
      end else begin
        mon_req = req_q.pop_front();
        check_output("req_vaddr", 64'(bus.rd_req_vaddr), 64'(mon_req.vaddr));
        check_output("req_len", 64'(bus.rd_req_len), 64'(mon_req.len));
        check_output("req_last", 64'(bus.rd_req_last), 64'(mon_req.last));
      end
    end
  end

  always @(negedge aclk) begin
    if (bus.m_tvalid && bus.m_tready) begin
      if (beat_q.size() == 0) begin
        check_output("unexpected_beat", 64'(bus.m_tdata), 64'd0);
      end else begin
        mon_beat = beat_q.pop_front();
        check_output("m_tdata", 64'(bus.m_tdata), 64'(mon_beat.data));
        check_output("m_tkeep", 64'(bus.m_tkeep), 64'(mon_beat.keep));
        check_output("m_tlast", 64'(bus.m_tlast), 64'(mon_beat.last));
      end
    end
  end

  always @(negedge aclk) begin
    if (bus.done_valid) begin
      if (done_q.size() == 0) begin
        check_output("unexpected_done", 64'(bus.done_len), 64'd0);
      end else begin
        mon_len = done_q.pop_front();
        check_output("done_len", 64'(bus.done_len), 64'(mon_len));
      end
    end
  end

  task automatic apply_stimulus();
    // Reset state and combinational pass-through
    repeat (3) tick();
    check_output("rst_desc_ready", 64'(bus.desc_ready), 64'd0);
    check_output("rst_req_valid", 64'(bus.rd_req_valid), 64'd0);
    check_output("rst_req_fields", 64'({bus.rd_req_vaddr, bus.rd_req_len, bus.rd_req_last}), 64'd0);
    check_output("rst_done", 64'({bus.done_valid, bus.done_len}), 64'd0);
    check_output("rst_passthru", 64'(bus.m_tdata), 64'hA5A5_0000_1234_5678);
    check_output("rst_s_tready", 64'(bus.s_tready), 64'd1);
    aresetn = 1'b1;
    tick();
    check_output("rel_desc_ready", 64'(bus.desc_ready), 64'd1);

    // Data in IDLE passes through without tlast
    send_segment(64'h100, 1, 1'b0, 1'b0);

    // 10000 bytes -> 4096, 4096, 1808
    push_req(48'h1000, 28'd4096, 1'b0);
    push_req(48'h2000, 28'd4096, 1'b0);
    push_req(48'h3000, 28'd1808, 1'b1);
    done_q.push_back(28'd10000);
    send_desc(48'h1000, 28'd10000);
    check_output("t1_req_n1", 64'(bus.rd_req_valid), 64'd1);
    tick();
    tick();
    send_segment(64'h1000, 2, 1'b0, 1'b0);
    pulse_cmpl();
    tick();
    tick();
    send_segment(64'h2000, 2, 1'b0, 1'b0);
    pulse_cmpl();
    send_segment(64'h3000, 3, 1'b1, 1'b0);
    pulse_cmpl();
    check_output("t1_done_pulse", 64'(bus.done_valid), 64'd1);
    tick();
    check_output("t1_done_single", 64'(bus.done_valid), 64'd0);
    check_output("t1_desc_ready", 64'(bus.desc_ready), 64'd1);

    // Zero-length buffer
    done_q.push_back(28'd0);
    send_desc(48'h5000, 28'd0);
    check_output("z_done", 64'(bus.done_valid), 64'd1);
    check_output("z_no_req", 64'(bus.rd_req_valid), 64'd0);
    check_output("z_desc_busy", 64'(bus.desc_ready), 64'd0);
    tick();
    check_output("z_desc_ready", 64'(bus.desc_ready), 64'd1);

    // Outstanding limit of 2 with completions withheld
    for (int k = 0; k < 5; k++) begin
      push_req(48'h10000 + 48'(k * XFER), 28'd4096, k == 4);
    end
    done_q.push_back(28'd20480);
    send_desc(48'h10000, 28'd20480);
    repeat (4) tick();
    check_output("lim_hold", 64'(bus.rd_req_valid), 64'd0);
    check_output("lim_issued_left", 64'(req_q.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      pulse_cmpl();
      check_output("lim_release", 64'(bus.rd_req_valid), 64'd1);
      tick();
      check_output("lim_refill", 64'(bus.rd_req_valid), 64'd0);
    end
    check_output("lim_all_issued", 64'(req_q.size()), 64'd0);
    for (int k = 0; k < 5; k++) begin
      send_segment(64'h4000 + 64'(k * 16), 1, k == 4, 1'b0);
    end
    pulse_cmpl();
    pulse_cmpl();
    check_output("lim_done", 64'(bus.done_valid), 64'd1);
    tick();

    // Backpressure on the first request, then final tlast and completion together
    bus.rd_req_ready = 1'b0;
    push_req(48'h20000, 28'd4096, 1'b0);
    push_req(48'h21000, 28'd4096, 1'b1);
    done_q.push_back(28'd8192);
    send_desc(48'h20000, 28'd8192);
    for (int k = 0; k < 5; k++) begin
      check_output("stall_valid", 64'(bus.rd_req_valid), 64'd1);
      check_output("stall_vaddr", 64'(bus.rd_req_vaddr), 64'h20000);
      check_output("stall_len", 64'(bus.rd_req_len), 64'd4096);
      tick();
    end
`ifdef INPUT_READER_STATS_EN
    check_output("stat_stall", 64'(stat_stall_cycles), 64'd5);
`endif
    bus.rd_req_ready = 1'b1;
    tick();
    tick();
    send_segment(64'h5000, 1, 1'b0, 1'b0);
    pulse_cmpl();
    send_segment(64'h6000, 2, 1'b1, 1'b1);
    check_output("same_done", 64'(bus.done_valid), 64'd1);
    tick();
    check_output("same_single", 64'(bus.done_valid), 64'd0);
    check_output("same_desc_ready", 64'(bus.desc_ready), 64'd1);
`ifdef INPUT_READER_STATS_EN
    check_output("stat_bytes", stat_bytes, 64'd38672);
`endif

    // Reset during ISSUE with two requests in flight
    push_req(48'h30000, 28'd4096, 1'b0);
    push_req(48'h31000, 28'd4096, 1'b0);
    send_desc(48'h30000, 28'd16384);
    repeat (3) tick();
    aresetn = 1'b0;
    #1;
    check_output("abort_req_valid", 64'(bus.rd_req_valid), 64'd0);
    check_output("abort_req_fields", 64'({bus.rd_req_vaddr, bus.rd_req_len, bus.rd_req_last}), 64'd0);
    check_output("abort_desc_ready", 64'(bus.desc_ready), 64'd0);
    check_output("abort_done", 64'({bus.done_valid, bus.done_len}), 64'd0);
`ifdef INPUT_READER_STATS_EN
    check_output("abort_stats", 64'(stat_stall_cycles) | stat_bytes, 64'd0);
`endif
    tick();
    aresetn = 1'b1;
    tick();
    check_output("abort_rel_ready", 64'(bus.desc_ready), 64'd1);
    pulse_cmpl();
    pulse_cmpl();
    push_req(48'h40000, 28'd4096, 1'b1);
    done_q.push_back(28'd4096);
    send_desc(48'h40000, 28'd4096);
    check_output("abort_new_req", 64'(bus.rd_req_valid), 64'd1);
    tick();
    send_segment(64'h9000, 2, 1'b1, 1'b0);
    pulse_cmpl();
    check_output("abort_new_done", 64'(bus.done_valid), 64'd1);
    repeat (2) tick();

    check_output("req_q_empty", 64'(req_q.size()), 64'd0);
    check_output("beat_q_empty", 64'(beat_q.size()), 64'd0);
    check_output("done_q_empty", 64'(done_q.size()), 64'd0);
  endtask

  initial begin
    bus.desc_valid    = 1'b0;
    bus.desc_vaddr    = '0;
    bus.desc_len      = '0;
    bus.rd_req_ready  = 1'b1;
    bus.rd_cmpl_valid = 1'b0;
    bus.s_tdata       = 64'hA5A5_0000_1234_5678;
    bus.s_tkeep       = '1;
    bus.s_tlast       = 1'b0;
    bus.s_tvalid      = 1'b0;
    bus.m_tready      = 1'b1;
    aresetn           = 1'b0;
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
